// File: rtl/gpr_exec_pkg.sv
// Shared definitions for the GPR execute unit: opcodes, instruction field
// positions, flag bit indices and FSM state encoding.
package gpr_exec_pkg;

    localparam logic [4:0] OP_MOVSGPR = 5'b00000;
    localparam logic [4:0] OP_MOV     = 5'b00001;
    localparam logic [4:0] OP_ADD     = 5'b00010;
    localparam logic [4:0] OP_SUB     = 5'b00011;
    localparam logic [4:0] OP_MUL     = 5'b00100;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 27;
    localparam int RDST_MSB  = 26;
    localparam int RDST_LSB  = 22;
    localparam int RSRC1_MSB = 21;
    localparam int RSRC1_LSB = 17;
    localparam int IMM_BIT   = 16;
    localparam int RSRC2_MSB = 15;
    localparam int RSRC2_LSB = 11;
    localparam int ISRC_MSB  = 15;
    localparam int ISRC_LSB  = 0;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

    function automatic logic is_legal_op(input logic [4:0] op);
        return op <= OP_MUL;
    endfunction

endpackage

// File: rtl/gpr_exec_unit_seq_multiplier.sv
// Radix-2 shift-add unsigned multiplier, one partial product per cycle.
// done/product are combinational and flag the cycle whose edge takes the final step.
import gpr_exec_pkg::*;

module seq_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0]   cnt;
    logic               busy_r;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;

    // Accumulator value after this cycle's step; the full product on the last step.
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = busy_r && (cnt == CNT_W'(WIDTH - 1));
    assign busy    = busy_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            cnt    <= '0;
        end else if (start) begin
            busy_r <= 1'b1;
            cnt    <= '0;
        end else if (busy_r) begin
            cnt <= cnt + 1'b1;
            if (done) begin
                busy_r <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
        end else if (busy_r) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/gpr_exec_unit.sv
// EX/WB execute unit: GPR file, SGPR, status flags, decode and handshake.
// movsgpr/mov/add/sub retire in one cycle; mul runs on the sequential multiplier.
import gpr_exec_pkg::*;

module gpr_exec_unit #(
    parameter int WIDTH = 16,
    parameter int NREG  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [3:0]       flags,
    output logic [WIDTH-1:0] sgpr,
    input  logic [4:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

    logic [WIDTH-1:0] gpr [NREG];
    logic [WIDTH-1:0] sgpr_r;
    logic [3:0]       flags_r;
    state_e           state;
    logic             done_r;
    logic             err_r;
    logic [IDX_W-1:0] mul_rdst;

    logic [4:0]       op;
    logic [4:0]       rdst;
    logic [4:0]       rsrc1;
    logic [4:0]       rsrc2;
    logic             imm;
    logic [15:0]      isrc;
    logic [WIDTH-1:0] imm_val;
    logic [WIDTH-1:0] src1_val;
    logic [WIDTH-1:0] src2_val;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic             uses_src1;
    logic             uses_src2;
    logic             legal;
    logic             accept;

    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic               mul_hi_nz;

    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [WIDTH-1:0]   wr_data;
    logic               sgpr_we;
    logic [WIDTH-1:0]   sgpr_d;
    logic               flags_we;
    logic [3:0]         flags_d;
    logic               retire;
    logic               retire_err;

    function automatic logic idx_ok(input logic [4:0] idx);
        return 32'(idx) < 32'(NREG);
    endfunction

    function automatic logic [3:0] pack_flags(input logic v, input logic c,
                                              input logic n, input logic z);
        logic [3:0] f;
        f         = '0;
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        return f;
    endfunction

    function automatic logic [3:0] move_flags(input logic [WIDTH-1:0] r);
        return pack_flags(1'b0, 1'b0, r[WIDTH-1], r == '0);
    endfunction

    // Overflow judged on the two's-complement view of the operands and result.
    function automatic logic [3:0] arith_flags(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] r,
                                               input logic carry,
                                               input logic is_sub);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic signed [WIDTH-1:0] sr;
        logic                    v;
        sa = a;
        sb = b;
        sr = r;
        if (is_sub) begin
            v = ((sa < 0) != (sb < 0)) && ((sr < 0) != (sa < 0));
        end else begin
            v = ((sa < 0) == (sb < 0)) && ((sr < 0) != (sa < 0));
        end
        return pack_flags(v, carry, r[WIDTH-1], r == '0);
    endfunction

    assign op    = instr[OP_MSB:OP_LSB];
    assign rdst  = instr[RDST_MSB:RDST_LSB];
    assign rsrc1 = instr[RSRC1_MSB:RSRC1_LSB];
    assign rsrc2 = instr[RSRC2_MSB:RSRC2_LSB];
    assign imm   = instr[IMM_BIT];
    assign isrc  = instr[ISRC_MSB:ISRC_LSB];

    assign imm_val  = WIDTH'(isrc);
    assign src1_val = idx_ok(rsrc1) ? gpr[rsrc1[IDX_W-1:0]] : '0;
    assign src2_val = idx_ok(rsrc2) ? gpr[rsrc2[IDX_W-1:0]] : '0;
    assign op_a     = src1_val;
    assign op_b     = imm ? imm_val : src2_val;
    assign add_full = {1'b0, op_a} + {1'b0, op_b};
    assign sub_full = {1'b0, op_a} - {1'b0, op_b};

    // Only indices the instruction actually reads count towards legality.
    assign uses_src1 = ((op == OP_MOV) && !imm) || (op == OP_ADD) ||
                       (op == OP_SUB) || (op == OP_MUL);
    assign uses_src2 = ((op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL)) && !imm;
    assign legal     = is_legal_op(op) && idx_ok(rdst) &&
                       (!uses_src1 || idx_ok(rsrc1)) &&
                       (!uses_src2 || idx_ok(rsrc2));

    assign busy     = (state == S_MUL) || mul_busy;
    assign in_ready = !busy;
    assign accept   = in_valid && in_ready;

    assign done     = done_r;
    assign err      = err_r;
    assign flags    = flags_r;
    assign sgpr     = sgpr_r;
    assign dbg_data = idx_ok(dbg_addr) ? gpr[dbg_addr[IDX_W-1:0]] : '0;

    assign mul_hi_nz = |mul_product[2*WIDTH-1:WIDTH];

    seq_multiplier #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        wr_en      = 1'b0;
        wr_idx     = rdst[IDX_W-1:0];
        wr_data    = '0;
        sgpr_we    = 1'b0;
        sgpr_d     = '0;
        flags_we   = 1'b0;
        flags_d    = '0;
        retire     = 1'b0;
        retire_err = 1'b0;
        mul_start  = 1'b0;
        if (state == S_MUL) begin
            if (mul_done) begin
                wr_en    = 1'b1;
                wr_idx   = mul_rdst;
                wr_data  = mul_product[WIDTH-1:0];
                sgpr_we  = 1'b1;
                sgpr_d   = mul_product[2*WIDTH-1:WIDTH];
                flags_we = 1'b1;
                flags_d  = pack_flags(mul_hi_nz, mul_hi_nz,
                                      mul_product[2*WIDTH-1], mul_product == '0);
                retire   = 1'b1;
            end
        end else if (accept) begin
            if (!legal) begin
                retire     = 1'b1;
                retire_err = 1'b1;
            end else begin
                case (op)
                    OP_MOVSGPR: begin
                        wr_en    = 1'b1;
                        wr_data  = sgpr_r;
                        flags_we = 1'b1;
                        flags_d  = move_flags(sgpr_r);
                        retire   = 1'b1;
                    end
                    OP_MOV: begin
                        wr_en    = 1'b1;
                        wr_data  = imm ? imm_val : src1_val;
                        flags_we = 1'b1;
                        flags_d  = move_flags(imm ? imm_val : src1_val);
                        retire   = 1'b1;
                    end
                    OP_ADD: begin
                        wr_en    = 1'b1;
                        wr_data  = add_full[WIDTH-1:0];
                        flags_we = 1'b1;
                        flags_d  = arith_flags(op_a, op_b, add_full[WIDTH-1:0],
                                               add_full[WIDTH], 1'b0);
                        retire   = 1'b1;
                    end
                    OP_SUB: begin
                        wr_en    = 1'b1;
                        wr_data  = sub_full[WIDTH-1:0];
                        flags_we = 1'b1;
                        flags_d  = arith_flags(op_a, op_b, sub_full[WIDTH-1:0],
                                               sub_full[WIDTH], 1'b1);
                        retire   = 1'b1;
                    end
                    OP_MUL: begin
                        mul_start = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                gpr[i] <= '0;
            end
            sgpr_r  <= '0;
            flags_r <= '0;
            state   <= S_IDLE;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            if (wr_en) begin
                gpr[wr_idx] <= wr_data;
            end
            if (sgpr_we) begin
                sgpr_r <= sgpr_d;
            end
            if (flags_we) begin
                flags_r <= flags_d;
            end
            done_r <= retire;
            err_r  <= retire_err;
            case (state)
                S_IDLE:  if (mul_start) state <= S_MUL;
                S_MUL:   if (mul_done)  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Destination of an in-flight mul, held until its writeback.
    always_ff @(posedge clk) begin
        if (mul_start) begin
            mul_rdst <= rdst[IDX_W-1:0];
        end
    end

endmodule

// File: tb/tb_gpr_exec_unit.sv
// Bench for gpr_exec_unit: directed scenarios plus random instructions
// checked against an arithmetic reference model of the register state.
module tb_gpr_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  flags;
    logic [15:0] sgpr;
    logic [4:0]  dbg_addr;
    logic [15:0] dbg_data;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] m_gpr [32];
    logic [15:0] m_sgpr;
    logic [3:0]  m_flags;

    bit          t_ill;
    bit          t_mul;
    int          nstall;
    int          ndone;
    int          rsel;
    logic [4:0]  r_op;
    logic [4:0]  r_rd;
    logic [4:0]  r_r1;
    logic [4:0]  r_r2;
    logic        r_imm;
    logic [15:0] r_low;

    gpr_exec_unit #(.WIDTH(16), .NREG(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .instr    (instr),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .flags    (flags),
        .sgpr     (sgpr),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] r1, input logic imm,
                                        input logic [15:0] low);
        return {op, rd, r1, imm, low};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_gpr[i] = 16'h0;
        m_sgpr  = 16'h0;
        m_flags = 4'h0;
    endfunction

    // Reference: plain integer arithmetic on the architectural state.
    function automatic void model_exec(input logic [31:0] ins, output bit ill, output bit ismul);
        int          op;
        int          rd;
        int          r1;
        int          r2;
        bit          imm;
        logic [15:0] av;
        logic [15:0] bv;
        longint      a;
        longint      b;
        longint      res;
        longint      p;
        int          sa;
        int          sb;
        int          sr;
        bit          v;
        bit          c;
        logic [15:0] r;
        op  = int'(ins[31:27]);
        rd  = int'(ins[26:22]);
        r1  = int'(ins[21:17]);
        r2  = int'(ins[15:11]);
        imm = ins[16];
        av  = m_gpr[r1];
        bv  = imm ? ins[15:0] : m_gpr[r2];
        a   = longint'(av);
        b   = longint'(bv);
        sa  = int'($signed(av));
        sb  = int'($signed(bv));
        ill   = (op > 4);
        ismul = (op == 4);
        if (ill) return;
        case (op)
            0, 1: begin
                r = (op == 0) ? m_sgpr : (imm ? ins[15:0] : m_gpr[r1]);
                m_gpr[rd] = r;
                m_flags   = {1'b0, 1'b0, r[15], r == 16'h0};
            end
            2, 3: begin
                if (op == 2) begin
                    res = a + b;
                    sr  = sa + sb;
                    c   = res > 65535;
                end else begin
                    res = a - b;
                    sr  = sa - sb;
                    c   = a < b;
                end
                v = (sr > 32767) || (sr < -32768);
                r = res[15:0];
                m_gpr[rd] = r;
                m_flags   = {v, c, r[15], r == 16'h0};
            end
            default: begin
                p = a * b;
                m_gpr[rd] = p[15:0];
                m_sgpr    = p[31:16];
                c         = p[31:16] != 0;
                m_flags   = {c, c, p[31], p == 0};
            end
        endcase
    endfunction

    // Issue one instruction, wait for its retirement and check the outcome.
    task automatic do_instr(input logic [31:0] ins);
        bit         ill;
        bit         ismul;
        int         waitc;
        int         nbusy;
        logic [4:0] rd;
        rd       = ins[26:22];
        in_valid = 1'b1;
        instr    = ins;
        waitc    = 0;
        while (!in_ready && waitc < 100) begin
            @(posedge clk); #1;
            waitc++;
        end
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_exec(ins, ill, ismul);
        if (ismul) begin
            nbusy = 0;
            for (int k = 0; k < 16; k++) begin
                if (busy && !in_ready && !done) nbusy++;
                @(posedge clk); #1;
            end
            check("mul_busy_cycles", nbusy, 16);
            check("mul_busy_drop", busy, 0);
        end
        check("done", done, 1);
        check("err", err, ill);
        check("flags", flags, m_flags);
        check("sgpr", sgpr, m_sgpr);
        dbg_addr = rd; #1;
        check("rdst_value", dbg_data, m_gpr[rd]);
    endtask

    task automatic sweep_regs(input string tag);
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i); #1;
            check($sformatf("%s_r%0d", tag, i), dbg_data, m_gpr[i]);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        in_valid = 1'b0;
        instr    = 32'h0;
        dbg_addr = 5'd0;
        rst_n    = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_flags", flags, 0);
        check("rst_sgpr", sgpr, 0);
        sweep_regs("rst");

        // mov R3,#0x1234 then back-to-back mov R2,R3
        do_instr(enc(5'd1, 5'd3, 5'd0, 1'b1, 16'h1234));
        check("mov_r3", dbg_data, 16'h1234);
        check("mov_flags", flags, 4'b0000);
        do_instr(enc(5'd1, 5'd2, 5'd3, 1'b0, 16'h0000));
        check("mov_r2_b2b", dbg_data, 16'h1234);
        @(posedge clk); #1;
        check("done_idle", done, 0);

        do_instr(enc(5'd2, 5'd4, 5'd3, 1'b1, 16'hEDCC));
        check("add_r4", dbg_data, 16'h0000);
        check("add_flags", flags, 4'b0101);
        do_instr(enc(5'd3, 5'd5, 5'd0, 1'b1, 16'h0001));
        check("sub_r5", dbg_data, 16'hFFFF);
        check("sub_flags", flags, 4'b0110);

        // mul with an add R9,R9,#1 held valid behind it
        @(posedge clk); #1;
        instr    = enc(5'd4, 5'd6, 5'd3, 1'b1, 16'h0100);
        in_valid = 1'b1;
        @(posedge clk); #1;
        model_exec(instr, t_ill, t_mul);
        instr  = enc(5'd2, 5'd9, 5'd9, 1'b1, 16'h0001);
        nstall = 0;
        while (!in_ready && nstall < 100) begin
            nstall++;
            @(posedge clk); #1;
        end
        check("stall_cycles", nstall, 16);
        check("mul_done", done, 1);
        check("mul_sgpr", sgpr, 16'h0012);
        check("mul_flags", flags, 4'b1100);
        dbg_addr = 5'd6; #1;
        check("mul_r6", dbg_data, 16'h3400);
        check("mul_r6_model", dbg_data, m_gpr[6]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_exec(instr, t_ill, t_mul);
        check("held_done", done, 1);
        check("held_flags", flags, m_flags);
        repeat (3) @(posedge clk);
        #1;
        check("held_done_idle", done, 0);
        dbg_addr = 5'd9; #1;
        check("held_once_r9", dbg_data, 16'h0001);

        do_instr(enc(5'd0, 5'd7, 5'd0, 1'b0, 16'h0000));
        check("movsgpr_r7", dbg_data, 16'h0012);
        do_instr(enc(5'b10110, 5'd3, 5'd3, 1'b1, 16'hFFFF));
        check("illegal_err", err, 1);
        check("illegal_r3", dbg_data, 16'h1234);
        sweep_regs("illegal");

        // reset asserted during the 8th mul cycle
        instr    = enc(5'd4, 5'd6, 5'd3, 1'b1, 16'h0100);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        ndone = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        check("abort_sgpr", sgpr, 0);
        check("abort_flags", flags, 0);
        check("abort_busy_after", busy, 0);
        dbg_addr = 5'd6; #1;
        check("abort_r6", dbg_data, 16'h0000);

        // randomized instruction stream over a small register window
        for (int n = 0; n < 60; n++) begin
            rsel  = int'($urandom_range(0, 11));
            r_op  = (rsel < 10) ? 5'(rsel % 5) : 5'($urandom_range(5, 31));
            r_rd  = 5'($urandom_range(0, 7));
            r_r1  = 5'($urandom_range(0, 7));
            r_r2  = 5'($urandom_range(0, 7));
            r_imm = 1'($urandom_range(0, 1));
            r_low = r_imm ? 16'($urandom) : {r_r2, 11'($urandom)};
            do_instr(enc(r_op, r_rd, r_r1, r_imm, r_low));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        sweep_regs("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gpr_exec_unit.md
# gpr_exec_unit

Parametrised, clocked execute unit for the five-stage CPU. It holds the general-purpose register file and the special high-product register (SGPR). It accepts one 32-bit instruction per handshake and executes movsgpr/mov/add/sub in a single cycle, or mul as a multi-cycle shift-add operation. It sits in the EX/WB position and adds registered state, status flags, backpressure and illegal-opcode reporting.

## Interface
- WIDTH, 16: data width of GPR/SGPR; legal range 16..32.
- NREG, 32: number of GPRs; legal range 2..32. Register index fields stay 5 bits; indices >= NREG are illegal.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction present on instr.
- in_ready  out  1  unit can accept; equals !busy.
- instr  in  32  fields: op[31:27], rdst[26:22], rsrc1[21:17], imm_mode[16], rsrc2[15:11], isrc[15:0].
- busy  out  1  mul in progress.
- done  out  1  one-cycle pulse after an instruction retires.
- err  out  1  one-cycle pulse, coincident with done, for an illegal instruction.
- flags  out  4  {V,C,N,Z}, registered.
- sgpr  out  WIDTH  SGPR contents.
- dbg_addr  in  5  debug read index.
- dbg_data  out  WIDTH  combinational read of GPR[dbg_addr]; returns 0 if dbg_addr >= NREG.

## Operation
- **Accept:** an instruction is accepted on a rising edge where in_valid && in_ready. Operands, rdst, op and imm_mode are snapshotted at accept, so rdst == rsrc is safe.
- **Immediate:** isrc is zero-extended to WIDTH.
- **Opcodes:** 00000 movsgpr, 00001 mov, 00010 add, 00011 sub, 00100 mul. All other opcodes are illegal.
- **movsgpr:** GPR[rdst] = SGPR. Z and N are updated; C and V are cleared.
- **mov:** GPR[rdst] = imm ? isrc : GPR[rsrc1]. Flags as for movsgpr.
- **add:** result = A + B. C = carry out of bit WIDTH-1. V = signed overflow. N = result MSB. Z = (result == 0).
- **sub:** result = A - B. C = borrow (A < B, unsigned). V = signed overflow. N and Z as for add.
- **mul:** unsigned product P = A * B, 2*WIDTH bits wide.
  - GPR[rdst] = P[WIDTH-1:0]; SGPR = P[2*WIDTH-1:WIDTH].
  - Z = (P == 0). N = P MSB. C = V = (SGPR != 0).
- **Illegal instruction:** an illegal opcode, or any used register index >= NREG. No GPR, SGPR or flag change; done and err pulse.
- **FSM states:** IDLE and MUL.
  - IDLE -> MUL when mul is accepted.
  - MUL -> IDLE when the iteration counter reaches WIDTH-1 (final step plus writeback).
- **Reset** (any time, including mid-mul) forces:
  - all GPRs 0, SGPR 0, flags 0;
  - state IDLE, counter 0;
  - busy 0, done 0, err 0, in_ready 1.
  - An aborted mul writes nothing.

## Timing
- **Single-cycle ops**
  - Accepted at edge E.
  - GPR, SGPR and flags update at E.
  - done is high during the cycle after E; dbg_data shows the new value in that cycle.
  - in_ready stays 1, so back-to-back issue at E+1 is legal and sees the updated registers.
- **mul**
  - Accepted at edge E; busy = 1 and in_ready = 0 from E.
  - One partial-product step per cycle, WIDTH steps in total.
  - Writeback at edge E+WIDTH; busy drops at E+WIDTH.
  - done is high in the cycle after E+WIDTH.
  - The next instruction can be accepted at E+WIDTH+1.
- **Stall:** while in_ready = 0, the producer holds instr/in_valid stable; nothing is dropped or duplicated.
- **done** never stays high for 2 consecutive cycles unless 2 instructions retire in consecutive cycles.

## Structure
- **Package gpr_exec_pkg** contains:
  - opcode localparams;
  - instruction field bit positions;
  - flag bit indices (Z=0, N=1, C=2, V=3);
  - FSM state encoding.
- **Sub-module seq_multiplier #(WIDTH):**
  - start/a/b inputs, busy/done/product outputs;
  - radix-2 shift-add, WIDTH cycles;
  - async active-low reset.
- The GPR array, SGPR, flags, decode and handshake stay in gpr_exec_unit.

## Test plan
Bench parameters: WIDTH = 16, NREG = 32.
- Reset release -> in_ready = 1, flags = 0, sgpr = 0; dbg_data = 0 for all 32 indices.
- mov R3, #0x1234 -> R3 = 0x1234 one cycle later; done pulses once; flags Z = 0, N = 0. Then, back-to-back, mov R2, R3 -> R2 = 0x1234.
- add R4, R3, #0xEDCC -> R4 = 0x0000, flags C = 1, Z = 1. Then sub R5, R0, #1 -> R5 = 0xFFFF, flags C = 1, N = 1, V = 0.
- mul R6, R3, #0x0100 with a second instruction held valid:
  - in_ready = 0 for 16 cycles;
  - then R6 = 0x3400, sgpr = 0x0012, C = V = 1;
  - the held instruction is accepted exactly once afterwards.
- movsgpr R7 after that mul -> R7 = 0x0012. Opcode 5'b10110 -> done and err pulse together; all registers unchanged.
- rst_n low during the 8th mul cycle -> after release, R6 = 0, sgpr = 0, busy = 0, in_ready = 1, no done pulse.
